// File: rtl/xif_custom_coproc.sv
// ---------------------------------------------------------------------------
// xif_custom_coproc
//   Minimal eXtension-interface coprocessor. Decodes custom-0 ALU ops
//   (ADD/XOR/MIN/MAX, signed compares), computes the result at issue time and
//   holds accepted instructions in an in-order queue until the core commits or
//   kills them. Committed heads are returned on the result channel in issue
//   order; killed heads are dropped silently.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   issue_*                  offload request: valid/ready, instr, operands, id;
//                            accept/writeback are combinational from instr
//   commit_valid_i/id/kill   commit (kill=0) or kill (kill=1) of an id
//   result_*                 result channel: valid/ready, id, data, rd, we
// ---------------------------------------------------------------------------
module xif_custom_coproc #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [31:0]     issue_instr_i,
    input  logic [XLEN-1:0] issue_rs0_i,
    input  logic [XLEN-1:0] issue_rs1_i,
    input  logic [ID_W-1:0] issue_id_i,
    output logic            issue_accept_o,
    output logic            issue_writeback_o,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [XLEN-1:0] result_data_o,
    output logic [4:0]      result_rd_o,
    output logic            result_we_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Queue storage; payload is not reset, it is only observed through valid
    logic [ID_W-1:0]  id_q   [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic             we_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, cmt_q, kill_q;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Decode / execute
    logic [2:0]      funct3;
    logic [4:0]      dec_rd;
    logic            op_ok;
    logic [XLEN-1:0] alu_res;
    logic            unused_instr;

    assign funct3       = issue_instr_i[14:12];
    assign dec_rd       = issue_instr_i[11:7];
    assign unused_instr = ^issue_instr_i[24:15];

    always_comb begin
        op_ok   = 1'b1;
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = issue_rs0_i + issue_rs1_i;
            3'b001:  alu_res = issue_rs0_i ^ issue_rs1_i;
            // Ties return rs0 for both MIN and MAX
            3'b010:  alu_res = ($signed(issue_rs0_i) <= $signed(issue_rs1_i)) ? issue_rs0_i : issue_rs1_i;
            3'b011:  alu_res = ($signed(issue_rs0_i) >= $signed(issue_rs1_i)) ? issue_rs0_i : issue_rs1_i;
            default: op_ok   = 1'b0;
        endcase
    end

    assign issue_accept_o    = (issue_instr_i[6:0] == 7'h0B) && (issue_instr_i[31:25] == 7'd0) && op_ok;
    assign issue_writeback_o = issue_accept_o && (dec_rd != 5'd0);
    assign issue_ready_o     = (count_q != CNT_W'(DEPTH));

    logic push, pop, head_vld;

    assign head_vld       = vld_q[rd_ptr_q];
    // Commit and kill are mutually exclusive per entry, so no kill mask here
    assign result_valid_o = head_vld && cmt_q[rd_ptr_q];
    assign push           = issue_valid_i && issue_ready_o && issue_accept_o;
    assign pop            = head_vld && (kill_q[rd_ptr_q] || (result_valid_o && result_ready_i));

    // Fields are forced to zero while no result is offered
    assign result_id_o   = result_valid_o ? id_q[rd_ptr_q]   : '0;
    assign result_data_o = result_valid_o ? data_q[rd_ptr_q] : '0;
    assign result_rd_o   = result_valid_o ? rd_q[rd_ptr_q]   : '0;
    assign result_we_o   = result_valid_o ? we_q[rd_ptr_q]   : 1'b0;

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q    <= '0;
            cmt_q    <= '0;
            kill_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (commit_valid_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (vld_q[i] && (id_q[i] == commit_id_i) && !cmt_q[i] && !kill_q[i]) begin
                        if (commit_kill_i) kill_q[i] <= 1'b1;
                        else               cmt_q[i]  <= 1'b1;
                    end
                end
            end
            if (pop) begin
                vld_q[rd_ptr_q]  <= 1'b0;
                cmt_q[rd_ptr_q]  <= 1'b0;
                kill_q[rd_ptr_q] <= 1'b0;
            end
            // Push last so a fresh entry always starts with clear flags
            if (push) begin
                vld_q[wr_ptr_q]  <= 1'b1;
                cmt_q[wr_ptr_q]  <= 1'b0;
                kill_q[wr_ptr_q] <= 1'b0;
                id_q[wr_ptr_q]   <= issue_id_i;
                rd_q[wr_ptr_q]   <= dec_rd;
                we_q[wr_ptr_q]   <= (dec_rd != 5'd0);
                data_q[wr_ptr_q] <= alu_res;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_xif_custom_coproc.sv
// ---------------------------------------------------------------------------
// tb_xif_custom_coproc
//   Directed bench for xif_custom_coproc: reset state, ALU ops, rejects,
//   kill ordering, full/backpressure and reset during drain.
// ---------------------------------------------------------------------------
module tb_xif_custom_coproc;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [31:0] issue_rs0_i, issue_rs1_i;
    logic [3:0]  issue_id_i;
    logic        issue_accept_o, issue_writeback_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o, result_ready_i;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    xif_custom_coproc #(.DEPTH(4), .ID_W(4), .XLEN(32)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_rs0_i       (issue_rs0_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_id_i        (issue_id_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_data_o     (result_data_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 10'd0, f3, rd, 7'h0B};
    endfunction

    // Every task starts and ends 1-2 time units after a rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input string tag, input logic [31:0] instr, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] id,
                            input logic exp_acc, input logic exp_wb);
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_rs0_i   = a;
        issue_rs1_i   = b;
        issue_id_i    = id;
        #1;
        check_vec({tag, "_ready"}, 32'(issue_ready_o), 32'd1);
        check_vec({tag, "_accept"}, 32'(issue_accept_o), 32'(exp_acc));
        check_vec({tag, "_wb"}, 32'(issue_writeback_o), 32'(exp_wb));
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [3:0] id, input logic [31:0] data,
                                input logic [4:0] rd, input logic we);
        check_vec({tag, "_valid"}, 32'(result_valid_o), 32'd1);
        check_vec({tag, "_id"}, 32'(result_id_o), 32'(id));
        check_vec({tag, "_data"}, result_data_o, data);
        check_vec({tag, "_rd"}, 32'(result_rd_o), 32'(rd));
        check_vec({tag, "_we"}, 32'(result_we_o), 32'(we));
    endtask

    task automatic take_result(input string tag, input logic [3:0] id, input logic [31:0] data,
                               input logic [4:0] rd, input logic we);
        check_result(tag, id, data, rd, we);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    logic [31:0] rej_tab [3];

    initial begin
        rst_i          = 1'b1;
        issue_valid_i  = 1'b0;
        issue_instr_i  = '0;
        issue_rs0_i    = '0;
        issue_rs1_i    = '0;
        issue_id_i     = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b0;

        // Reset
        tick();
        tick();
        check_vec("rst_ready", 32'(issue_ready_o), 32'd1);
        check_vec("rst_rvalid", 32'(result_valid_o), 32'd0);
        check_vec("rst_rid", 32'(result_id_o), 32'd0);
        check_vec("rst_rdata", result_data_o, 32'd0);
        check_vec("rst_rrd", 32'(result_rd_o), 32'd0);
        check_vec("rst_rwe", 32'(result_we_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Single ADD with wraparound
        do_issue("add", mk(3'b000, 5'd5), 32'hFFFF_FFFF, 32'd2, 4'd3, 1'b1, 1'b1);
        check_vec("add_precommit", 32'(result_valid_o), 32'd0);
        do_commit(4'd3, 1'b0);
        take_result("add_res", 4'd3, 32'h0000_0001, 5'd5, 1'b1);
        check_vec("add_drained", 32'(result_valid_o), 32'd0);

        // Rejects: wrong opcode, nonzero funct7, unsupported funct3
        rej_tab[0] = 32'h0000_0033;
        rej_tab[1] = mk(3'b000, 5'd5) | 32'h0200_0000;
        rej_tab[2] = mk(3'b100, 5'd5);
        for (int i = 0; i < 3; i++) begin
            do_issue($sformatf("rej%0d", i), rej_tab[i], 32'd7, 32'd9, 4'(i + 12), 1'b0, 1'b0);
        end
        do_commit(4'd12, 1'b0);
        do_commit(4'd13, 1'b0);
        do_commit(4'd14, 1'b0);
        tick();
        check_vec("rej_noresult", 32'(result_valid_o), 32'd0);

        // Signed MIN / MAX, rd=0 suppresses writeback
        do_issue("min", mk(3'b010, 5'd7), 32'h8000_0000, 32'd1, 4'd4, 1'b1, 1'b1);
        do_issue("max", mk(3'b011, 5'd0), 32'h8000_0000, 32'd1, 4'd5, 1'b1, 1'b0);
        do_commit(4'd4, 1'b0);
        check_result("min_early", 4'd4, 32'h8000_0000, 5'd7, 1'b1);
        do_commit(4'd5, 1'b0);
        // Result held stable under backpressure
        take_result("min_res", 4'd4, 32'h8000_0000, 5'd7, 1'b1);
        take_result("max_res", 4'd5, 32'h0000_0001, 5'd0, 1'b0);
        check_vec("minmax_drained", 32'(result_valid_o), 32'd0);

        // Kill ordering
        do_issue("k1", mk(3'b000, 5'd1), 32'd10, 32'd20, 4'd1, 1'b1, 1'b1);
        do_issue("k2", mk(3'b001, 5'd2), 32'd1, 32'd3, 4'd2, 1'b1, 1'b1);
        do_issue("k3", mk(3'b001, 5'd3), 32'hA5A5_0F0F, 32'hFFFF_0000, 4'd3, 1'b1, 1'b1);
        do_commit(4'd2, 1'b1);
        check_vec("k_after_kill", 32'(result_valid_o), 32'd0);
        do_commit(4'd3, 1'b0);
        check_vec("k_head_blocks", 32'(result_valid_o), 32'd0);
        do_commit(4'd1, 1'b0);
        take_result("k_res1", 4'd1, 32'd30, 5'd1, 1'b1);
        check_vec("k_killed_head", 32'(result_valid_o), 32'd0);
        tick();
        take_result("k_res3", 4'd3, 32'h5A5A_0F0F, 5'd3, 1'b1);
        check_vec("k_drained", 32'(result_valid_o), 32'd0);

        // Full / backpressure
        for (int i = 0; i < 4; i++) begin
            do_issue($sformatf("full%0d", i), mk(3'b000, 5'(10 + i)), 32'(i), 32'd100,
                     4'(8 + i), 1'b1, 1'b1);
        end
        check_vec("full_ready", 32'(issue_ready_o), 32'd0);
        // An offer while full must not be taken
        issue_valid_i = 1'b1;
        issue_instr_i = mk(3'b000, 5'd20);
        issue_id_i    = 4'd15;
        tick();
        issue_valid_i = 1'b0;
        check_vec("full_still", 32'(issue_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) do_commit(4'(8 + i), 1'b0);
        result_ready_i = 1'b1;
        #1;
        check_result("drain0", 4'd8, 32'd100, 5'd10, 1'b1);
        tick();
        check_vec("drain_ready", 32'(issue_ready_o), 32'd1);
        check_result("drain1", 4'd9, 32'd101, 5'd11, 1'b1);
        tick();
        check_result("drain2", 4'd10, 32'd102, 5'd12, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i          = 1'b0;
        result_ready_i = 1'b0;
        check_vec("mrst_rvalid", 32'(result_valid_o), 32'd0);
        check_vec("mrst_rdata", result_data_o, 32'd0);
        check_vec("mrst_ready", 32'(issue_ready_o), 32'd1);
        tick();
        tick();
        check_vec("mrst_empty", 32'(result_valid_o), 32'd0);
        // Queue must be empty: exactly four more entries fit
        for (int i = 0; i < 4; i++) begin
            do_issue($sformatf("refill%0d", i), mk(3'b001, 5'd1), 32'd0, 32'd0, 4'(i), 1'b1, 1'b1);
        end
        check_vec("refill_full", 32'(issue_ready_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xif_custom_coproc.md
# xif_custom_coproc

Minimal coprocessor on the far side of the core's eXtension interface (XIF). It answers the issue handshake for a small set of custom-0 ALU instructions. Accepted instructions are buffered in a 4-entry in-order queue until the core commits or kills them. Committed instructions return their result on the XIF result channel; this gives the bench a real responder for the core's offload path.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- ID_W, 4, instruction id width
- XLEN, 32, data width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- issue_valid_i  in  1  core presents offload request
- issue_ready_o  out  1  coprocessor can take request
- issue_instr_i  in  32  instruction word
- issue_rs0_i  in  XLEN  rs1 operand
- issue_rs1_i  in  XLEN  rs2 operand
- issue_id_i  in  ID_W  instruction id
- issue_accept_o  out  1  instruction accepted (valid with handshake)
- issue_writeback_o  out  1  accepted instruction will write rd
- commit_valid_i  in  1  commit event
- commit_id_i  in  ID_W  id being committed/killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_W  id of result
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register
- result_we_o  out  1  register write enable

## Operation
- Decode: accepted iff opcode instr[6:0]=7'h0B, funct7 instr[31:25]=0, and funct3 instr[14:12] ∈ {000 ADD, 001 XOR, 010 MIN signed, 011 MAX signed}.
- All other words: accept=0, writeback=0. Handshake still completes; nothing is queued.
- issue_ready_o = !full. issue_ready_o is combinational from registered queue state.
- issue_accept_o and issue_writeback_o are combinational from issue_instr_i. They are meaningful only while issue_valid_i is high.
  - issue_writeback_o = accept & (rd≠0).
- Issue handshake = issue_valid_i & issue_ready_o.
- On a handshake with accept=1, push one entry: {id, rd=instr[11:7], we=(rd≠0), data}. data is computed at issue.
- Arithmetic:
  - ADD wraps modulo 2^XLEN.
  - XOR is bitwise.
  - MIN and MAX compare as two's complement; on equal operands, return rs0.
- Each entry has flags committed and killed, both cleared on push.
- Commit event: applies to every valid entry whose id equals commit_id_i and is not yet committed or killed.
  - commit_kill_i=0 sets committed; commit_kill_i=1 sets killed.
  - Commit events naming absent ids are ignored.
- Head processing each cycle:
  - Head killed: pop silently; no result.
  - Head committed: result_valid_o=1 with the head's fields.
  - Pop on result_valid_o & result_ready_i.
- Results are returned strictly in issue order.
- Once asserted, result_valid_o and all result_* fields hold stable until the handshake completes.
- Push and pop in the same cycle are allowed when not full; the count is unchanged.
- Pointers wrap modulo DEPTH. Count has log2(DEPTH)+1 bits.
- A commit event in the same cycle as the push of the same id is not visible; the core never does this.

## Timing
- Reset values:
  - issue_ready_o=1.
  - result_valid_o=0; result_id/data/rd/we = 0.
  - Queue empty; all flags clear.
- Reset mid-operation: all entries are discarded on the next edge, including committed-but-unreturned ones. No result is emitted after reset.
- Issue response: 0-cycle (same cycle as issue_valid_i).
- Issue at edge N, commit at edge ≥N+1: result_valid_o rises the cycle after the commit edge, provided the entry is at head.
- Killed head: popped one cycle after the kill is registered. The next entry can present its result the following cycle.
- Back-to-back results: one per cycle while result_ready_i is held high and head entries are committed.
- Full (count=DEPTH): issue_ready_o=0. It returns to 1 the cycle after a pop.

## Test plan
- Reset: assert rst_i 2 cycles → issue_ready_o=1, result_valid_o=0, all result fields 0.
- Single ADD:
  - Issue instr funct3=000, rd=5, rs0=32'hFFFF_FFFF, rs1=2, id=3 → accept=1, writeback=1.
  - Commit id 3 → next cycle result_valid_o=1, data=32'h1, rd=5, we=1, id=3.
- Reject: issue opcode 7'h33 → accept=0, writeback=0, handshake completes; no result ever appears.
- MIN/MAX signed:
  - rs0=32'h8000_0000, rs1=1: MIN returns 32'h8000_0000; MAX returns 1.
  - rd=0 → writeback=0, we=0.
- Kill ordering:
  - Issue ids 1, 2, 3; kill 2; commit 3, then 1.
  - → results id 1 then id 3, in order; no result for id 2.
- Full/backpressure:
  - Issue 4 accepted with result_ready_i=0 → issue_ready_o=0.
  - Commit all and raise result_ready_i → 4 results on consecutive cycles; issue_ready_o=1 one cycle after the first pop.
  - Assert rst_i mid-drain → result_valid_o=0 the next cycle and the queue is empty.
